alu_multicycle: RTL

//  Parametrised, handshaked successor to the combinational datapath ALU.
//  - Adds xor, logical shifts and multiply to add/sub/and/or.
//  - Shifts and multiply run iteratively over several cycles; the control unit stalls on in_ready/out_valid.
//  - Produces zero/carry/overflow flags alongside the result.

---
 rtl/alu_multicycle.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/and/or/xor, iterative
// 1-bit-per-cycle shifts and shift-add multiply, with zero/carry/overflow flags.
module alu_multicycle #(
    parameter int word_size = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           operation,
    input  logic [word_size-1:0] operandA,
    input  logic [word_size-1:0] operandB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] result,
    output logic                 zero,
    output logic                 carry,
    output logic                 overflow
);
    localparam int sh_w  = $clog2(word_size);
    localparam int cnt_w = sh_w + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           op_reg;
    logic [word_size-1:0] a_reg, b_reg, acc_reg;
    logic [cnt_w-1:0]     count_reg;
    logic [word_size-1:0] result_reg;
    logic                 zero_reg, carry_reg, overflow_reg;

    logic                 accept, is_iter, last_step;
    logic [sh_w-1:0]      k;
    logic [word_size:0]   sum_wide, diff_wide;
    logic [word_size-1:0] single_result;
    logic                 single_carry, single_overflow;
    logic [word_size-1:0] a_step, b_step, acc_step, step_value;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;

    assign accept    = in_valid && (state_reg == IDLE);
    assign k         = operandB[sh_w-1:0];
    // A zero shift amount completes immediately, like the logic ops.
    assign is_iter   = (operation == OP_MUL) ||
                       (((operation == OP_SLL) || (operation == OP_SRL)) && (k != '0));
    assign last_step = (state_reg == BUSY) && (count_reg == cnt_w'(1));

    always_comb begin
        sum_wide        = {1'b0, operandA} + {1'b0, operandB};
        diff_wide       = {1'b0, operandA} - {1'b0, operandB};
        single_result   = operandA;
        single_carry    = 1'b0;
        single_overflow = 1'b0;
        case (operation)
            OP_ADD: begin
                single_result   = sum_wide[word_size-1:0];
                single_carry    = sum_wide[word_size];
                single_overflow = (operandA[word_size-1] == operandB[word_size-1]) &&
                                  (sum_wide[word_size-1] != operandA[word_size-1]);
            end
            OP_SUB: begin
                single_result   = diff_wide[word_size-1:0];
                single_carry    = ~diff_wide[word_size];
                single_overflow = (operandA[word_size-1] != operandB[word_size-1]) &&
                                  (diff_wide[word_size-1] != operandA[word_size-1]);
            end
            OP_AND:  single_result = operandA & operandB;
            OP_OR:   single_result = operandA | operandB;
            OP_XOR:  single_result = operandA ^ operandB;
            default: single_result = operandA;
        endcase
    end

    // One iteration: a 1-bit shift, or one shift-add multiply step.
    always_comb begin
        a_step   = a_reg << 1;
        b_step   = b_reg >> 1;
        acc_step = acc_reg;
        case (op_reg)
            OP_SRL:  a_step = a_reg >> 1;
            OP_MUL:  if (b_reg[0]) acc_step = acc_reg + a_reg;
            default: a_step = a_reg << 1;
        endcase
        step_value = (op_reg == OP_MUL) ? acc_step : a_step;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = is_iter ? BUSY : DONE;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= OP_ADD;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            op_reg    <= operation;
            a_reg     <= operandA;
            b_reg     <= operandB;
            acc_reg   <= '0;
            count_reg <= (operation == OP_MUL) ? cnt_w'(word_size) : {1'b0, k};
            if (!is_iter) begin
                result_reg   <= single_result;
                zero_reg     <= (single_result == '0);
                carry_reg    <= single_carry;
                overflow_reg <= single_overflow;
            end
        end else if (state_reg == BUSY) begin
            a_reg     <= a_step;
            b_reg     <= b_step;
            acc_reg   <= acc_step;
            count_reg <= count_reg - cnt_w'(1);
            if (last_step) begin
                result_reg   <= step_value;
                zero_reg     <= (step_value == '0);
                carry_reg    <= 1'b0;
                overflow_reg <= 1'b0;
            end
        end
    end
endmodule
